// File: rtl/mem_tg2_mon_pkg.sv
// Shared types and constants for the memory traffic-gen status monitor.
package mem_tg2_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } t_tg_mon_state;

  localparam int CLK_CNT_W = 64;
  localparam logic [CLK_CNT_W-1:0] CLK_CNT_MAX = '1;

  typedef struct packed {
    logic pass;
    logic fail;
    logic timeout;
  } t_tg_mon_result;

endpackage

// File: rtl/mem_tg2_chan_mon.sv
// One channel of the TG2 status monitor: run FSM, saturating cycle counter and
// optional watchdog (present only when MEM_TG2_WATCHDOG_EN is defined).
module mem_tg2_chan_mon
  import mem_tg2_mon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned WD_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 active,
  input  logic                 complete,
  input  logic                 failed,
  output t_tg_mon_result       result,
  output logic [CLK_CNT_W-1:0] clock_count
);

  t_tg_mon_state        state_q, state_d;
  t_tg_mon_result       result_q, result_d;
  logic [CLK_CNT_W-1:0] clock_count_q, clock_count_d;

`ifdef MEM_TG2_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, WD_W};
`endif

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    clock_count_d = clock_count_q;
`ifdef MEM_TG2_WATCHDOG_EN
    wd_d          = wd_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // Clearing flags on restart lets the downstream edge detector re-fire.
        if (start) begin
          state_d       = RUN;
          result_d      = '0;
          clock_count_d = '0;
`ifdef MEM_TG2_WATCHDOG_EN
          wd_d          = '0;
`endif
        end
      end
      RUN: begin
        if (clock_count_q != CLK_CNT_MAX) begin
          clock_count_d = clock_count_q + 1'b1;
        end
`ifdef MEM_TG2_WATCHDOG_EN
        wd_d = wd_q + 1'b1;
`endif
        if (complete) begin
          state_d       = DONE;
          result_d.fail = failed;
          result_d.pass = ~failed;
`ifdef MEM_TG2_WATCHDOG_EN
        end else if (wd_q == WD_LAST) begin
          state_d          = DONE;
          result_d.timeout = 1'b1;
`endif
        end else if (!active) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      result_q      <= '0;
      clock_count_q <= '0;
`ifdef MEM_TG2_WATCHDOG_EN
      wd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      clock_count_q <= clock_count_d;
`ifdef MEM_TG2_WATCHDOG_EN
      wd_q          <= wd_d;
`endif
    end
  end

  assign result      = result_q;
  assign clock_count = clock_count_q;

endmodule

// File: rtl/mem_tg2_status_mon.sv
// Per-channel TG2 status monitor feeding the traffic-gen CSR block.
// Optional watchdog timeout enabled by defining MEM_TG2_WATCHDOG_EN.
module mem_tg2_status_mon
  import mem_tg2_mon_pkg::*;
#(
  parameter int unsigned NUM_TG         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned WD_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_TG-1:0]    mem_tg_active,
  input  logic [NUM_TG-1:0]    tg_test_complete,
  input  logic [NUM_TG-1:0]    tg_test_failed,
  output logic [NUM_TG-1:0]    tg_pass,
  output logic [NUM_TG-1:0]    tg_fail,
  output logic [NUM_TG-1:0]    tg_timeout,
  output logic [CLK_CNT_W-1:0] clock_count [NUM_TG]
);

  logic [NUM_TG-1:0] active_q, active_d;
  logic [NUM_TG-1:0] start;

  always_comb begin
    active_d = mem_tg_active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

  // Runs are launched only on a rising edge of the host's active level.
  assign start = mem_tg_active & ~active_q;

  for (genvar gi = 0; gi < NUM_TG; gi++) begin : g_ch
    t_tg_mon_result result;

    mem_tg2_chan_mon #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .WD_W           (WD_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .start       (start[gi]),
      .active      (mem_tg_active[gi]),
      .complete    (tg_test_complete[gi]),
      .failed      (tg_test_failed[gi]),
      .result      (result),
      .clock_count (clock_count[gi])
    );

    assign tg_pass[gi]    = result.pass;
    assign tg_fail[gi]    = result.fail;
    assign tg_timeout[gi] = result.timeout;
  end

endmodule

// File: tb/tb_mem_tg2_status_mon.sv
// Scoreboard bench for mem_tg2_status_mon: directed runs plus random traffic
// against a run-level reference model; honours MEM_TG2_WATCHDOG_EN.
module tb_mem_tg2_status_mon;

  localparam int N = 4;
  localparam int T = 1000;
`ifdef MEM_TG2_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FORCE_VAL = 64'hFFFF_FFFF_FFFF_FFFD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] act = '0;
  logic [N-1:0] cmp = '0;
  logic [N-1:0] fl  = '0;
  logic [N-1:0] pass_o, fail_o, to_o;
  logic [63:0] cnt_o [N];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit do_force = 1'b0;

  always #5 clk = ~clk;

  mem_tg2_status_mon #(
    .NUM_TG         (N),
    .TIMEOUT_CYCLES (T),
    .WD_W           (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_tg_active    (act),
    .tg_test_complete (cmp),
    .tg_test_failed   (fl),
    .tg_pass          (pass_o),
    .tg_fail          (fail_o),
    .tg_timeout       (to_o),
    .clock_count      (cnt_o)
  );

  typedef struct packed {
    logic [31:0]       cyc;
    logic [N-1:0]      pass;
    logic [N-1:0]      fail;
    logic [N-1:0]      to;
    logic [N-1:0][63:0] cnt;
  } exp_t;

  exp_t sb [$];

  // Reference model: a run is "in progress" or not; its length drives both
  // the reported count (saturated) and the watchdog limit.
  bit          m_run  [N];
  bit          m_prev [N];
  bit          m_pass [N];
  bit          m_fail [N];
  bit          m_to   [N];
  logic [63:0] m_len  [N];
  logic [63:0] m_cnt  [N];

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_run[c] = 0; m_prev[c] = 0; m_pass[c] = 0; m_fail[c] = 0; m_to[c] = 0;
        m_len[c] = 0; m_cnt[c] = 0;
      end else begin
        if (!m_run[c]) begin
          if (act[c] && !m_prev[c]) begin
            m_run[c] = 1; m_len[c] = 0; m_cnt[c] = 0;
            m_pass[c] = 0; m_fail[c] = 0; m_to[c] = 0;
          end
        end else begin
          m_len[c] = m_len[c] + 1;
          if (m_cnt[c] != ALL1) m_cnt[c] = m_cnt[c] + 1;
          if (cmp[c]) begin
            m_run[c] = 0; m_pass[c] = !fl[c]; m_fail[c] = fl[c];
            $display("cyc=%0d ch%0d run end result=%s count=%0d", cyc, c,
                     fl[c] ? "failed" : "passed", m_cnt[c]);
          end else if (WD_EN && m_len[c] == 64'(T)) begin
            m_run[c] = 0; m_to[c] = 1;
            $display("cyc=%0d ch%0d run end result=timeout count=%0d", cyc, c, m_cnt[c]);
          end else if (!act[c]) begin
            m_run[c] = 0;
            $display("cyc=%0d ch%0d run end result=abort count=%0d", cyc, c, m_cnt[c]);
          end
        end
        m_prev[c] = act[c];
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] a, input logic [N-1:0] c,
                       input logic [N-1:0] f);
    exp_t e;
    @(negedge clk);
    rst = r; act = a; cmp = c; fl = f;
    if (do_force) begin
      force dut.g_ch[0].u_chan.clock_count_q = FORCE_VAL;
      #1;
      release dut.g_ch[0].u_chan.clock_count_q;
      m_cnt[0] = FORCE_VAL;
      do_force = 1'b0;
    end
    @(posedge clk);
    model_edge();
    e.cyc = cyc;
    for (int i = 0; i < N; i++) begin
      e.pass[i] = m_pass[i]; e.fail[i] = m_fail[i]; e.to[i] = m_to[i];
      e.cnt[i]  = m_cnt[i];
    end
    sb.push_back(e);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: every edge presents a fresh output set; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 3;
        if (pass_o !== e.pass) begin
          failures++;
          $display("FAIL sb_pass cyc=%0d got=%b expected=%b", e.cyc, pass_o, e.pass);
        end
        if (fail_o !== e.fail) begin
          failures++;
          $display("FAIL sb_fail cyc=%0d got=%b expected=%b", e.cyc, fail_o, e.fail);
        end
        if (to_o !== e.to) begin
          failures++;
          $display("FAIL sb_timeout cyc=%0d got=%b expected=%b", e.cyc, to_o, e.to);
        end
        for (int i = 0; i < N; i++) begin
          checks++;
          if (cnt_o[i] !== e.cnt[i]) begin
            failures++;
            $display("FAIL sb_count%0d cyc=%0d got=%0h expected=%0h", i, e.cyc, cnt_o[i], e.cnt[i]);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] a, c, f;
    logic r;

    repeat (3) cycle(1, 4'b0000, 4'b0000, 4'b0000);
    #1;
    chk("reset_pass", 64'(pass_o), 0);
    chk("reset_fail", 64'(fail_o), 0);
    chk("reset_to", 64'(to_o), 0);
    chk("reset_cnt3", cnt_o[3], 0);

    // ch0: start at edge 0, passing complete at edge 10
    repeat (10) cycle(0, 4'b0001, 4'b0000, 4'b0000);
    cycle(0, 4'b0001, 4'b0001, 4'b0000);
    #1;
    chk("ch0_pass", 64'(pass_o[0]), 1);
    chk("ch0_cnt", cnt_o[0], 10);
    chk("ch0_fail_to", 64'({fail_o[0], to_o[0]}), 0);
    chk("ch1_untouched", cnt_o[1], 0);

    // ch1: failing complete at edge 5, then restart clears the flag
    repeat (5) cycle(0, 4'b0011, 4'b0000, 4'b0000);
    cycle(0, 4'b0011, 4'b0010, 4'b0010);
    #1;
    chk("ch1_fail", 64'(fail_o[1]), 1);
    chk("ch1_cnt", cnt_o[1], 5);
    chk("ch0_held_cnt", cnt_o[0], 10);
    cycle(0, 4'b0001, 4'b0000, 4'b0000);
    cycle(0, 4'b0011, 4'b0000, 4'b0000);
    #1;
    chk("ch1_restart_fail", 64'(fail_o[1]), 0);
    chk("ch1_restart_cnt", cnt_o[1], 0);
    repeat (3) cycle(0, 4'b0011, 4'b0000, 4'b0000);
    #1;
    chk("ch1_rerun_cnt", cnt_o[1], 3);
    cycle(0, 4'b0011, 4'b0010, 4'b0000);

    // ch2: host abort at edge 20
    repeat (20) cycle(0, 4'b0111, 4'b0000, 4'b0000);
    cycle(0, 4'b0011, 4'b0000, 4'b0000);
    #1;
    chk("ch2_abort_cnt", cnt_o[2], 20);
    chk("ch2_abort_flags", 64'({pass_o[2], fail_o[2], to_o[2]}), 0);
    repeat (5) cycle(0, 4'b0011, 4'b0000, 4'b0000);
    #1;
    chk("ch2_abort_hold", cnt_o[2], 20);

    // ch3: watchdog behaviour
    repeat (T) cycle(0, 4'b1011, 4'b0000, 4'b0000);
`ifdef MEM_TG2_WATCHDOG_EN
    cycle(0, 4'b1011, 4'b0000, 4'b0000);
    #1;
    chk("ch3_timeout", 64'(to_o[3]), 1);
    chk("ch3_timeout_cnt", cnt_o[3], T);
    cycle(0, 4'b0011, 4'b0000, 4'b0000);
    repeat (T) cycle(0, 4'b1011, 4'b0000, 4'b0000);
    cycle(0, 4'b1011, 4'b1000, 4'b0000);
    #1;
    chk("ch3_cmp_wins_pass", 64'(pass_o[3]), 1);
    chk("ch3_cmp_wins_to", 64'(to_o[3]), 0);
    chk("ch3_cmp_wins_cnt", cnt_o[3], T);
`else
    repeat (T) cycle(0, 4'b1011, 4'b0000, 4'b0000);
    #1;
    chk("ch3_no_wd_to", 64'(to_o[3]), 0);
    chk("ch3_no_wd_cnt", cnt_o[3], 2 * T - 1);
    cycle(0, 4'b1011, 4'b0000, 4'b0000);
    #1;
    chk("ch3_no_wd_running", cnt_o[3], 2 * T);
`endif

    // ch0: counter saturation
    cycle(0, 4'b0010, 4'b0000, 4'b0000);
    cycle(0, 4'b0011, 4'b0000, 4'b0000);
    do_force = 1'b1;
    repeat (5) cycle(0, 4'b0011, 4'b0000, 4'b0000);
    #1;
    chk("ch0_saturate", cnt_o[0], ALL1);
    cycle(0, 4'b0011, 4'b0001, 4'b0001);
    #1;
    chk("ch0_sat_fail", 64'(fail_o[0]), 1);

    // random traffic
    a = 4'b0011;
    for (int k = 0; k < 8000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(49) == 0) a[i] = ~a[i];
        c[i] = ($urandom_range(299) == 0);
      end
      f = N'($urandom);
      r = ($urandom_range(2999) == 0);
      cycle(r, a, c, f);
    end

    // reset in the middle of runs on every channel
    cycle(0, 4'b0000, 4'b0000, 4'b0000);
    repeat (8) cycle(0, 4'b1111, 4'b0000, 4'b0000);
    cycle(1, 4'b1111, 4'b0000, 4'b0000);
    #1;
    chk("midrst_flags", 64'({pass_o, fail_o, to_o}), 0);
    for (int i = 0; i < N; i++) chk("midrst_cnt", cnt_o[i], 0);
    repeat (2) cycle(0, 4'b0000, 4'b0000, 4'b0000);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_tg2_status_mon.md
Name: mem_tg2_status_mon

Overview:
- Per-channel status monitor that sits directly upstream of the memory traffic-gen CSR block.
- Consumes each channel's mem_tg_active from the CSR block and raw completion/error indications from the TG2 cores.
- Produces the level-type tg_pass/tg_fail/tg_timeout flags and the 64-bit per-channel clock_count that the CSR block edge-detects and exposes to the host.
- One instance per memory subsystem, on the CSR clock domain.

Parameters:
- NUM_TG, 4, number of traffic-gen channels.
- TIMEOUT_CYCLES, 32'd100_000_000, watchdog limit in clk cycles per run; must be ≥2.
- WD_W, 32, watchdog counter width; TIMEOUT_CYCLES must fit in WD_W bits.

Ports:
- clk  in  1  CSR/TG clock.
- rst  in  1  synchronous, active-high reset.
- mem_tg_active  in  NUM_TG  per-channel run request/active level from the CSR block.
- tg_test_complete  in  NUM_TG  TG2 core test-done level, sampled only in RUN.
- tg_test_failed  in  NUM_TG  TG2 core error level, qualified by tg_test_complete.
- tg_pass  out  NUM_TG  registered level: last run passed.
- tg_fail  out  NUM_TG  registered level: last run failed.
- tg_timeout  out  NUM_TG  registered level: last run hit the watchdog.
- clock_count  out  64 x NUM_TG (unpacked [NUM_TG])  cycles spent in the last/current run.

Behaviour:
- Reset is synchronous, active-high; only one clock. Reset values: every state = IDLE, every flag = 0, clock_count = 0, watchdog = 0, active_q = 0.
- Per-channel FSM, channels fully independent. States: IDLE, RUN, DONE.
- start[c] = mem_tg_active[c] & ~active_q[c], where active_q is the previous-cycle registered copy of mem_tg_active.
- IDLE or DONE, start: go to RUN; clear tg_pass/tg_fail/tg_timeout; clock_count <= 0; watchdog <= 0.
  - Flags clear on restart so the downstream rising-edge detector re-fires on the next result.
- RUN, each edge:
  - clock_count <= clock_count + 1, saturating at 64'hFFFF_FFFF_FFFF_FFFF (no wrap).
  - watchdog <= watchdog + 1.
- RUN, tg_test_complete=1: go to DONE.
  - tg_fail <= tg_test_failed; tg_pass <= ~tg_test_failed.
  - clock_count still takes this edge's increment.
- RUN, no complete and watchdog == TIMEOUT_CYCLES-1: go to DONE, tg_timeout <= 1.
- Complete and watchdog expiry on the same edge: complete wins; tg_timeout stays 0.
- RUN, mem_tg_active=0 with no complete (host abort): go to IDLE.
  - No flag set; clock_count holds.
  - Complete on that same edge wins over abort.
- DONE: flags and clock_count hold until the next start.
  - tg_test_complete is ignored outside RUN.
  - Starts are edge-triggered, so mem_tg_active held high in DONE does not restart.
- Latency: complete sampled at edge N → flag visible after edge N (one cycle).
  - Run with start at edge 0 and complete at edge K gives clock_count = K.
- At most one of pass/fail/timeout is high per channel at any time.
- Reset mid-run: everything returns to reset values on that edge; nothing is held.

Optional Feature:
- Macro: MEM_TG2_WATCHDOG_EN.
- Defined: watchdog counter and timeout transition present as above.
- Undefined:
  - No watchdog logic; tg_timeout tied to 0.
  - RUN exits only on complete or abort.
  - TIMEOUT_CYCLES and WD_W are unused.

Decomposition:
- Shared package mem_tg2_mon_pkg:
  - enum t_tg_mon_state {IDLE, RUN, DONE};
  - localparam CLK_CNT_W = 64;
  - typedef t_tg_mon_result {pass, fail, timeout}.
- Sub-module mem_tg2_chan_mon: one channel's FSM, counter and watchdog.
- Top generates NUM_TG instances and handles active_q/start detection.

Test Plan:
- Start at edge 0 on ch0, complete=1 with failed=0 at edge 10 → tg_pass[0]=1 after edge 10, clock_count[0]=10, tg_fail/tg_timeout=0; other channels unchanged.
- Ch1 run with complete=1 and failed=1 at edge 5 → tg_fail[1]=1, clock_count[1]=5; then a restart clears tg_fail[1] on the start edge and clock_count[1] restarts from 0.
- Watchdog enabled, TIMEOUT_CYCLES=1000, no complete → tg_timeout=1 after edge 1000, clock_count=1000; complete on that same edge instead → tg_pass=1, tg_timeout=0.
- Abort: drop mem_tg_active at edge 20 with no complete → state IDLE, all flags 0, clock_count=20 held.
- Force clock_count near 2^64-2 (or use a bind/force), run 5 cycles → saturates at all-ones.
- Assert rst mid-run on all channels → all outputs 0 next cycle.
- Build with the macro undefined and run 2000 cycles without complete → tg_timeout stays 0, FSM stays RUN.
